// File: rtl/gpio_pattern_sequencer_pkg.sv
// Shared types for the GPIO walking-one sequencer: sequencing modes and FSM states.
package gpio_seq_pkg;

  typedef enum logic [1:0] {
    FWD_ONCE  = 2'd0,
    FWD_LOOP  = 2'd1,
    REV_ONCE  = 2'd2,
    PING_PONG = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gpio_pattern_sequencer_if.sv
// Control/status and pad-side bundle of the sequencer; master drives control, slave is the sequencer.
interface gpio_pattern_sequencer_if
  import gpio_seq_pkg::*;
#(
  parameter int unsigned NUM_PINS   = 34,
  parameter int unsigned PRESCALE_W = 14
);
  localparam int unsigned IDX_W = $clog2(NUM_PINS);

  logic                  en;
  logic                  run;
  logic                  stop;
  mode_t                 mode;
  logic [PRESCALE_W-1:0] prescaler;
  logic [NUM_PINS-1:0]   pins_out;
  logic [NUM_PINS-1:0]   pins_oeb;
  logic                  busy;
  logic [IDX_W-1:0]      active_idx;
  logic                  done;

  modport master (
    output en, run, stop, mode, prescaler,
    input  pins_out, pins_oeb, busy, active_idx, done
  );

  modport slave (
    input  en, run, stop, mode, prescaler,
    output pins_out, pins_oeb, busy, active_idx, done
  );

endinterface

// File: rtl/gpio_pattern_sequencer_tick_gen.sv
// Dwell timer: terminal count latched on load, emits a one-cycle tick when the count reaches it.
module gpio_seq_tick_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  input  logic             cnt_en,
  output logic             tick
);

  logic [CNT_W-1:0] term_q;
  logic [CNT_W-1:0] cnt_q;

  // A zero terminal count never ticks, which stalls the sequencer on its current pin.
  assign tick = cnt_en && (term_q != '0) && (cnt_q == term_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      term_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      term_q <= load_val;
      cnt_q  <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gpio_pattern_sequencer.sv
// Walking-one GPIO sequencer: FSM, pin index/direction, one-hot decode and enable gating.
module gpio_pattern_sequencer
  import gpio_seq_pkg::*;
#(
  parameter int unsigned NUM_PINS        = 34,
  parameter int unsigned PRESCALE_W      = 14,
  parameter int unsigned CYCLES_PER_TICK = 10000
) (
  input logic                     clk,
  input logic                     rst,
  gpio_pattern_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_PINS);
  localparam int unsigned CNT_W = PRESCALE_W + $clog2(CYCLES_PER_TICK) + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PINS - 1);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             start;
  logic             up;
  logic             tick;
  logic             cnt_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] term_start;
  logic [NUM_PINS-1:0] pins;

  assign term_start = CNT_W'(bus.prescaler) * CNT_W'(CYCLES_PER_TICK);
  assign cnt_en     = (state_q == RUN) && bus.run && bus.en && !bus.stop;
  assign cnt_clr    = (state_q != RUN) || !bus.en || bus.stop;

  gpio_seq_tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .load_val(term_start),
    .clr     (cnt_clr),
    .cnt_en  (cnt_en),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= FWD_ONCE;
      idx_q   <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    start   = 1'b0;
    up      = dir_q;
    if (!bus.en || bus.stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_d = RUN;
            start   = 1'b1;
            mode_d  = bus.mode;
            idx_d   = (bus.mode == REV_ONCE) ? LAST : '0;
            dir_d   = (bus.mode != REV_ONCE);
          end
        end
        RUN: begin
          if (tick) begin
            unique case (mode_q)
              FWD_ONCE: begin
                if (idx_q == LAST) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                end else begin
                  idx_d = idx_q + IDX_W'(1);
                end
              end
              FWD_LOOP: begin
                if (idx_q == LAST) begin
                  idx_d  = '0;
                  done_d = 1'b1;
                end else begin
                  idx_d = idx_q + IDX_W'(1);
                end
              end
              REV_ONCE: begin
                if (idx_q == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                end else begin
                  idx_d = idx_q - IDX_W'(1);
                end
              end
              PING_PONG: begin
                // Direction is forced at the ends so neither end pin is repeated.
                if (idx_q == '0)       up = 1'b1;
                else if (idx_q == LAST) up = 1'b0;
                idx_d  = up ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
                dir_d  = up;
                done_d = !up && (idx_q == IDX_W'(1));
              end
              default: state_d = IDLE;
            endcase
          end
        end
        DONE: begin
          if (!bus.run) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pins = '0;
    if (state_q == RUN && bus.en) pins[idx_q] = 1'b1;
  end

  assign bus.pins_out   = pins;
  assign bus.pins_oeb   = {NUM_PINS{~bus.en}};
  assign bus.busy       = (state_q == RUN);
  assign bus.active_idx = (state_q == RUN) ? idx_q : '0;
  assign bus.done       = done_q;

endmodule
